// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - load/store operation codes as carried on in_ld_op / in_st_op
//   - access FSM state encodings
//   - lane_idx_w(): number of address bits that select a byte lane in a data word
package mem_pkg;

  typedef enum logic [2:0] {
    LdNone = 3'd0,
    LdB    = 3'd1,
    LdBu   = 3'd2,
    LdH    = 3'd3,
    LdHu   = 3'd4,
    LdW    = 3'd5
  } ld_op_e;

  typedef enum logic [1:0] {
    StNone = 2'd0,
    StB    = 2'd1,
    StH    = 2'd2,
    StW    = 2'd3
  } st_op_e;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemReq  = 2'd1,
    MemWait = 2'd2
  } mem_state_e;

  function automatic int unsigned lane_idx_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: selects the addressed byte/halfword/word from a read data word and
// sign- or zero-extends it to DATA_W. Purely combinational.
// Ports:
//   rdata   read data word from memory
//   lane    byte lane of the access (low address bits)
//   ld_op   load operation code (LdNone..LdW); unknown codes give zero
//   result  aligned, extended load result
module mem_load_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = lane_idx_w(DATA_W)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic [2:0]        ld_op,
  output logic [DATA_W-1:0] result
);

  logic [LANE_W-1:0] lane_h;
  logic [LANE_W-1:0] lane_w;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       word_v;

  // Halfword and word accesses ignore the low lane bits below their own size.
  assign lane_h = lane & ~LANE_W'(1);
  assign lane_w = lane & ~LANE_W'(3);

  assign byte_v = 8'(rdata >> {lane, 3'b000});
  assign half_v = 16'(rdata >> {lane_h, 3'b000});
  assign word_v = 32'(rdata >> {lane_w, 3'b000});

  always_comb begin
    result = '0;
    case (ld_op)
      LdB:     result = DATA_W'($signed(byte_v));
      LdBu:    result = DATA_W'(byte_v);
      LdH:     result = DATA_W'($signed(half_v));
      LdHu:    result = DATA_W'(half_v);
      LdW:     result = DATA_W'($signed(word_v));
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage. Registers the EX result into a single slot, runs a req/gnt + rvalid
// data-memory access for loads and stores, aligns load data and drives the WB and ID
// forwarding buses. stall_req freezes IF..EX while an access is outstanding.
// Optional feature macro: MEM_ALIGN_EXC_EN -- misaligned halfword/word accesses are not
// issued, suppress writeback and are reported on exc_valid / exc_badaddr.
// Ports:
//   clk, rst (async, active-low)
//   stall_in, in_valid, in_pc, in_ld_op, in_st_op, in_addr, in_st_data, in_rf_we, in_rf_waddr
//   in_ready, stall_req                      : handshake towards EX / front end
//   dmem_req/we/addr/wdata, dmem_gnt/rvalid/rdata : data memory port
//   wb_valid/pc/rf_we/rf_waddr/rf_wdata      : writeback bus
//   exc_valid, exc_badaddr                   : alignment fault (MEM_ALIGN_EXC_EN only)
//   fwd_we/waddr/wdata, fwd_pend             : forwarding bus to ID
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 in_valid,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [2:0]           in_ld_op,
  input  logic [1:0]           in_st_op,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]    in_st_data,
  input  logic                 in_rf_we,
  input  logic [RF_ADDR_W-1:0] in_rf_waddr,
  output logic                 in_ready,
  output logic                 stall_req,
  output logic                 dmem_req,
  output logic [DATA_W/8-1:0]  dmem_we,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]    dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [DATA_W-1:0]    dmem_rdata,
  output logic                 wb_valid,
  output logic [PC_W-1:0]      wb_pc,
  output logic                 wb_rf_we,
  output logic [RF_ADDR_W-1:0] wb_rf_waddr,
  output logic [DATA_W-1:0]    wb_rf_wdata,
`ifdef MEM_ALIGN_EXC_EN
  output logic                 exc_valid,
  output logic [ADDR_W-1:0]    exc_badaddr,
`endif
  output logic                 fwd_we,
  output logic [RF_ADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]    fwd_wdata,
  output logic                 fwd_pend
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = lane_idx_w(DATA_W);

  mem_state_e state_q, state_d;

  logic                 valid_q;
  logic [PC_W-1:0]      pc_q;
  logic [2:0]           ld_op_q;
  logic [1:0]           st_op_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    st_data_q;
  logic                 rf_we_q;
  logic [RF_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]    result_q;

  logic                 in_is_load;
  logic                 in_is_store;
  logic                 in_misalign;
  logic                 in_is_mem;
  logic                 slot_is_load;
  logic                 load_done;
  logic [LANE_W-1:0]    lane;
  logic [DATA_W-1:0]    ld_result;
  logic [NB-1:0]        st_we;
  logic [DATA_W-1:0]    st_wdata;

  assign in_ready    = (state_q == MemIdle) && !stall_in;
  assign in_is_load  = (in_ld_op != LdNone) && (in_ld_op <= LdW);
  assign in_is_store = (in_st_op != StNone);

  always_comb begin
    in_misalign = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
    if (((in_ld_op == LdH) || (in_ld_op == LdHu) || (!in_is_load && in_st_op == StH))
        && in_addr[0]) begin
      in_misalign = 1'b1;
    end
    if (((in_ld_op == LdW) || (!in_is_load && in_st_op == StW)) && (in_addr[1:0] != 2'b00)) begin
      in_misalign = 1'b1;
    end
`endif
  end

  // A misaligned access (fault build only) is retired as a plain op with no memory traffic.
  assign in_is_mem = (in_is_load || in_is_store) && !in_misalign;

  assign slot_is_load = (ld_op_q != LdNone) && (ld_op_q <= LdW);
  assign lane         = addr_q[LANE_W-1:0];

  // Load completes either with the grant (zero-wait memory) or later while waiting.
  assign load_done = dmem_rvalid &&
                     (((state_q == MemReq) && dmem_gnt && slot_is_load) || (state_q == MemWait));

  always_comb begin
    state_d = state_q;
    case (state_q)
      MemIdle: begin
        if (in_ready && in_valid && in_is_mem) state_d = MemReq;
      end
      MemReq: begin
        if (dmem_gnt) state_d = (slot_is_load && !dmem_rvalid) ? MemWait : MemIdle;
      end
      MemWait: begin
        if (dmem_rvalid) state_d = MemIdle;
      end
      default: state_d = MemIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MemIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      ld_op_q    <= '0;
      st_op_q    <= '0;
      addr_q     <= '0;
      st_data_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      result_q   <= '0;
    end else if (in_ready) begin
      valid_q    <= in_valid;
      pc_q       <= in_pc;
      // Misaligned ops keep no op code so the slot never looks like a pending access.
      ld_op_q    <= (in_is_load && !in_misalign) ? in_ld_op : 3'(LdNone);
      st_op_q    <= (!in_is_load && !in_misalign) ? in_st_op : 2'(StNone);
      addr_q     <= in_addr;
      st_data_q  <= in_st_data;
      rf_we_q    <= in_rf_we && !in_misalign;
      rf_waddr_q <= in_rf_waddr;
      result_q   <= DATA_W'(in_addr);
    end else if (load_done) begin
      result_q   <= ld_result;
    end
  end

`ifdef MEM_ALIGN_EXC_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
    end else if (in_ready) begin
      mis_q <= in_valid && in_misalign;
    end
  end

  assign exc_valid   = wb_valid && mis_q;
  assign exc_badaddr = exc_valid ? addr_q : '0;
`endif

  mem_load_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_load_align (
    .rdata  (dmem_rdata),
    .lane   (lane),
    .ld_op  (ld_op_q),
    .result (ld_result)
  );

  always_comb begin
    st_we    = '0;
    st_wdata = '0;
    case (st_op_q)
      StB: begin
        st_we    = NB'(1) << lane;
        st_wdata = {NB{st_data_q[7:0]}};
      end
      StH: begin
        st_we    = NB'(2'b11) << (lane & ~LANE_W'(1));
        st_wdata = {(NB / 2){st_data_q[15:0]}};
      end
      StW: begin
        st_we    = NB'(4'hF) << (lane & ~LANE_W'(3));
        st_wdata = {(DATA_W / 32){st_data_q[31:0]}};
      end
      default: ;
    endcase
  end

  // Port fields come straight from the held slot, so they stay stable until the grant.
  assign dmem_req   = (state_q == MemReq);
  assign dmem_we    = dmem_req ? st_we : '0;
  assign dmem_addr  = dmem_req ? (addr_q & ~ADDR_W'(NB - 1)) : '0;
  assign dmem_wdata = dmem_req ? st_wdata : '0;

  assign stall_req = (state_q != MemIdle);

  assign wb_valid    = valid_q && (state_q == MemIdle);
  assign wb_pc       = pc_q;
  assign wb_rf_we    = wb_valid && rf_we_q;
  assign wb_rf_waddr = rf_waddr_q;
  assign wb_rf_wdata = result_q;

  assign fwd_we    = wb_rf_we;
  assign fwd_waddr = rf_waddr_q;
  assign fwd_wdata = result_q;
  assign fwd_pend  = valid_q && slot_is_load && (state_q != MemIdle);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (default 32-bit configuration). Expected WB
// transactions are queued at issue time and compared when the stage retires them.
module tb_mem_access_unit;

  localparam logic [2:0] LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4, LW = 3'd5;
  localparam logic [1:0] SB = 2'd1, SH = 2'd2, SW = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [2:0]  in_ld_op;
  logic [1:0]  in_st_op;
  logic [31:0] in_addr;
  logic [31:0] in_st_data;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic        in_ready;
  logic        stall_req;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        fwd_pend;
`ifdef MEM_ALIGN_EXC_EN
  logic        exc_valid;
  logic [31:0] exc_badaddr;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      n_cmp = 0;
  int      n_err = 0;

  mem_access_unit u_dut (
    .clk         (clk),
    .rst         (rst_n),
    .stall_in    (stall_in),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_ld_op    (in_ld_op),
    .in_st_op    (in_st_op),
    .in_addr     (in_addr),
    .in_st_data  (in_st_data),
    .in_rf_we    (in_rf_we),
    .in_rf_waddr (in_rf_waddr),
    .in_ready    (in_ready),
    .stall_req   (stall_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_pc       (wb_pc),
    .wb_rf_we    (wb_rf_we),
    .wb_rf_waddr (wb_rf_waddr),
    .wb_rf_wdata (wb_rf_wdata),
`ifdef MEM_ALIGN_EXC_EN
    .exc_valid   (exc_valid),
    .exc_badaddr (exc_badaddr),
`endif
    .fwd_we      (fwd_we),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_pend    (fwd_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retirement happens on the edge ending a cycle with wb_valid and no downstream stall.
  always @(negedge clk) begin
    if (rst_n && wb_valid && !stall_in) begin
      if (exp_q.size() == 0) begin
        check_eq("wb_unexpected", 64'(wb_valid), 64'd0);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        check_eq("wb_pc", 64'(wb_pc), 64'(e.pc));
        check_eq("wb_rf_we", 64'(wb_rf_we), 64'(e.we));
        check_eq("fwd_we", 64'(fwd_we), 64'(e.we));
        if (e.we) begin
          check_eq("wb_rf_waddr", 64'(wb_rf_waddr), 64'(e.waddr));
          check_eq("wb_rf_wdata", 64'(wb_rf_wdata), 64'(e.wdata));
          check_eq("fwd_wdata", 64'(fwd_wdata), 64'(e.wdata));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [2:0] ld, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic we,
                       input logic [4:0] wa, input logic [31:0] exp_wdata,
                       input logic exp_we);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("issue_timeout", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_ld_op    = ld;
    in_st_op    = st;
    in_addr     = addr;
    in_st_data  = sdata;
    in_rf_we    = we;
    in_rf_waddr = wa;
    exp_q.push_back('{pc: pc, we: exp_we, waddr: wa, wdata: exp_wdata});
    tick();
    in_valid = 1'b0;
    in_ld_op = '0;
    in_st_op = '0;
    in_rf_we = 1'b0;
  endtask

  // Grant after gnt_dly request cycles; for loads, rvalid rv_dly cycles after the grant.
  task automatic mem_cycle(input int gnt_dly, input int rv_dly, input logic is_load,
                           input logic [31:0] rdata);
    for (int i = 0; i < gnt_dly; i++) tick();
    dmem_gnt    = 1'b1;
    dmem_rvalid = is_load && (rv_dly == 0);
    dmem_rdata  = rdata;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    if (is_load && rv_dly > 0) begin
      for (int i = 1; i < rv_dly; i++) tick();
      dmem_rvalid = 1'b1;
      tick();
      dmem_rvalid = 1'b0;
    end
  endtask

  task automatic run_load(input logic [31:0] pc, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp, input int gd,
                          input int rd);
    issue(pc, op, 2'd0, addr, 32'h0, 1'b1, 5'd7, exp, 1'b1);
    check_eq("ld_fwd_pend", 64'(fwd_pend), 64'd1);
    mem_cycle(gd, rd, 1'b1, rdata);
    tick();
  endtask

  task automatic run_store(input logic [31:0] pc, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata, input int gd);
    issue(pc, 3'd0, op, addr, data, 1'b0, 5'd0, addr, 1'b0);
    check_eq("st_req", 64'(dmem_req), 64'd1);
    check_eq("st_we", 64'(dmem_we), 64'(exp_we));
    check_eq("st_wdata", 64'(dmem_wdata), 64'(exp_wdata));
    check_eq("st_addr", 64'(dmem_addr), 64'(addr & 32'hFFFF_FFFC));
    mem_cycle(gd, 0, 1'b0, 32'h0);
    check_eq("st_done_stall", 64'(stall_req), 64'd0);
    tick();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    int req_cnt;
    int unstable;

    rst_n       = 1'b0;
    stall_in    = 1'b0;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_ld_op    = '0;
    in_st_op    = '0;
    in_addr     = '0;
    in_st_data  = '0;
    in_rf_we    = 1'b0;
    in_rf_waddr = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;

    #3;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_dmem_req", 64'(dmem_req), 64'd0);
    check_eq("rst_stall_req", 64'(stall_req), 64'd0);
    check_eq("rst_fwd_pend", 64'(fwd_pend), 64'd0);
    check_eq("rst_wb_wdata", 64'(wb_rf_wdata), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Non-memory op: WB next cycle, no access.
    issue(32'h100, 3'd0, 2'd0, 32'h1234, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b1);
    check_eq("alu_no_req", 64'(dmem_req), 64'd0);
    check_eq("alu_wb_valid", 64'(wb_valid), 64'd1);
    tick();

    // LB, grant and data together: one stall cycle.
    issue(32'h104, LB, 2'd0, 32'h103, 32'h0, 1'b1, 5'd6, 32'hFFFF_FF80, 1'b1);
    check_eq("lb_req", 64'(dmem_req), 64'd1);
    check_eq("lb_stall", 64'(stall_req), 64'd1);
    check_eq("lb_addr", 64'(dmem_addr), 64'h100);
    check_eq("lb_we", 64'(dmem_we), 64'd0);
    mem_cycle(0, 0, 1'b1, 32'h80FF_FF00);
    check_eq("lb_stall_end", 64'(stall_req), 64'd0);
    tick();

    // LHU with a slow grant and slow data.
    issue(32'h108, LHU, 2'd0, 32'h102, 32'h0, 1'b1, 5'd8, 32'h0000_ABCD, 1'b1);
    stall_cnt = 0;
    req_cnt   = 0;
    unstable  = 0;
    for (int c = 1; c <= 8; c++) begin
      dmem_gnt    = (c == 3);
      dmem_rvalid = (c == 5);
      dmem_rdata  = (c == 5) ? 32'hABCD_1234 : 32'hDEAD_BEEF;
      if (stall_req) stall_cnt++;
      if (dmem_req) begin
        req_cnt++;
        if (dmem_addr != 32'h100 || dmem_we != 4'b0000) unstable++;
      end
      tick();
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    check_eq("lhu_stall_cycles", 64'(stall_cnt), 64'd5);
    check_eq("lhu_req_cycles", 64'(req_cnt), 64'd3);
    check_eq("lhu_req_stable", 64'(unstable), 64'd0);

    // More load/store alignments.
    run_load(32'h10C, LH, 32'h100, 32'h1234_8001, 32'hFFFF_8001, 0, 0);
    run_load(32'h110, LBU, 32'h101, 32'h0000_9A00, 32'h0000_009A, 1, 0);
    run_load(32'h114, LW, 32'h10C, 32'h89AB_CDEF, 32'h89AB_CDEF, 1, 1);
    run_load(32'h118, LB, 32'h102, 32'h007F_0000, 32'h0000_007F, 0, 2);
    run_load(32'h11C, LH, 32'h102, 32'h7FFE_0000, 32'h0000_7FFE, 2, 0);
    run_store(32'h120, SB, 32'h101, 32'h0000_0055, 4'b0010, 32'h5555_5555, 0);
    run_store(32'h124, SH, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 2);
    run_store(32'h128, SW, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);

    // Load completing under a downstream stall: WB bus holds, no new capture.
    issue(32'h300, LW, 2'd0, 32'h108, 32'h0, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b1);
    stall_in = 1'b1;
    mem_cycle(0, 1, 1'b1, 32'hCAFE_F00D);
    in_valid    = 1'b1;
    in_pc       = 32'h304;
    in_addr     = 32'h9999;
    in_rf_we    = 1'b1;
    in_rf_waddr = 5'd10;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      check_eq("stall_wb_valid", 64'(wb_valid), 64'd1);
      check_eq("stall_wb_wdata", 64'(wb_rf_wdata), 64'hCAFE_F00D);
      check_eq("stall_wb_pc", 64'(wb_pc), 64'h300);
      tick();
    end
    in_valid = 1'b0;
    in_rf_we = 1'b0;
    stall_in = 1'b0;
    tick();
    tick();

    // Reset while requesting: request drops immediately.
    issue(32'h500, LW, 2'd0, 32'h200, 32'h0, 1'b1, 5'd11, 32'h0, 1'b1);
    check_eq("rreq_req", 64'(dmem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rreq_req_drop", 64'(dmem_req), 64'd0);
    check_eq("rreq_stall", 64'(stall_req), 64'd0);
    check_eq("rreq_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset while waiting for data: a late rvalid is ignored.
    issue(32'h504, LW, 2'd0, 32'h204, 32'h0, 1'b1, 5'd12, 32'h0, 1'b1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check_eq("rwait_stall", 64'(stall_req), 64'd1);
    check_eq("rwait_pend", 64'(fwd_pend), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rwait_req", 64'(dmem_req), 64'd0);
    check_eq("rwait_stall_drop", 64'(stall_req), 64'd0);
    exp_q.delete();
    tick();
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    tick();
    dmem_rvalid = 1'b0;
    check_eq("rwait_no_wb0", 64'(wb_valid), 64'd0);
    tick();
    check_eq("rwait_no_wb1", 64'(wb_valid), 64'd0);

`ifdef MEM_ALIGN_EXC_EN
    // Misaligned word load: faulted, no access, no writeback.
    issue(32'h600, LW, 2'd0, 32'h102, 32'h0, 1'b1, 5'd3, 32'h0, 1'b0);
    check_eq("mis_no_req", 64'(dmem_req), 64'd0);
    check_eq("mis_stall", 64'(stall_req), 64'd0);
    check_eq("mis_exc_valid", 64'(exc_valid), 64'd1);
    check_eq("mis_exc_badaddr", 64'(exc_badaddr), 64'h102);
    tick();
`endif

    tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
